// File: rtl/dac_share_arb.sv
// dac_share_arb
//   Round-robin scheduler sharing one threshold DAC between N_CH channel
//   measurement controllers. Keeps the latest threshold posted by each channel,
//   issues one DAC write at a time and waits for its completion. It then reports
//   a per-channel ready that means "the last written value is at the DAC".
//
// Ports
//   clk_i       clock, rising edge
//   arst_ni     asynchronous active-low reset
//   req_wre_i   per-channel single-cycle write strobe
//   req_data_i  per-channel threshold, channel k at [k*DW +: DW]
//   req_rdy_o   per-channel: last written value applied at the DAC
//   dac_data_o  value for the DAC write
//   dac_ch_o    channel being serviced
//   dac_wre_o   one-cycle DAC write strobe
//   dac_done_i  one-cycle DAC completion pulse (ignored outside WAIT)
//   busy_o      write in flight
//   timeout_o   sticky abort flag, cleared by clr_i
//   clr_i       clears timeout_o
module dac_share_arb #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                     clk_i,
  input  logic                     arst_ni,
  input  logic [N_CH-1:0]          req_wre_i,
  input  logic [N_CH*DW-1:0]       req_data_i,
  output logic [N_CH-1:0]          req_rdy_o,
  output logic [DW-1:0]            dac_data_o,
  output logic [$clog2(N_CH)-1:0]  dac_ch_o,
  output logic                     dac_wre_o,
  input  logic                     dac_done_i,
  output logic                     busy_o,
  output logic                     timeout_o,
  input  logic                     clr_i
);

  localparam int unsigned CW = $clog2(N_CH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [N_CH-1:0]   pending_q;
  logic [DW-1:0]     data_q [N_CH];
  logic [CW-1:0]     last_grant_q;
  logic [TW-1:0]     cnt_q;

  logic              grant_valid;
  logic [CW-1:0]     grant_idx;
  logic              grant_fire;
  logic              done_fire;
  logic              abort_fire;

  // Search starts just after the last grant and wraps, so each pending
  // channel is reached within N_CH grants.
  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      cand = 32'(last_grant_q) + i;
      if (cand >= N_CH) cand = cand - N_CH;
      if (!grant_valid && pending_q[cand[CW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[CW-1:0];
      end
    end
  end

  assign grant_fire = (state_q == S_IDLE) && grant_valid;
  assign done_fire  = (state_q == S_WAIT) && dac_done_i;
  // A done on the abort edge still counts as a completion.
  assign abort_fire = (state_q == S_WAIT) && !dac_done_i && (cnt_q == TW'(TIMEOUT));

  // State register
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (grant_valid)             state_d = S_WAIT;
      S_WAIT: if (done_fire || abort_fire) state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_o = (state_q == S_WAIT);
  end

  // Latest posted value per channel; no reset needed, pending gates its use.
  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (req_wre_i[k]) data_q[k] <= req_data_i[k*DW +: DW];
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      pending_q    <= '0;
      req_rdy_o    <= '0;
      dac_data_o   <= '0;
      dac_ch_o     <= '0;
      dac_wre_o    <= 1'b0;
      timeout_o    <= 1'b0;
      last_grant_q <= CW'(N_CH - 1);
      cnt_q        <= '0;
    end else begin
      dac_wre_o <= 1'b0;

      if (grant_fire) begin
        dac_data_o   <= data_q[grant_idx];
        dac_ch_o     <= grant_idx;
        dac_wre_o    <= 1'b1;
        last_grant_q <= grant_idx;
        cnt_q        <= '0;
      end else if ((state_q == S_WAIT) && (cnt_q != TW'(TIMEOUT))) begin
        cnt_q <= cnt_q + TW'(1);
      end

      // A new write on a channel overrides grant/done/abort effects on it.
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (req_wre_i[k]) begin
          pending_q[k] <= 1'b1;
          req_rdy_o[k] <= 1'b0;
        end else begin
          if (grant_fire && (grant_idx == CW'(k))) pending_q[k] <= 1'b0;
          if (abort_fire && (dac_ch_o == CW'(k)))  pending_q[k] <= 1'b1;
          if (done_fire && (dac_ch_o == CW'(k)) && !pending_q[k])
            req_rdy_o[k] <= 1'b1;
        end
      end

      if (abort_fire)  timeout_o <= 1'b1;
      else if (clr_i)  timeout_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_share_arb.sv
module tb_dac_share_arb;

  localparam int unsigned N_CH = 4;
  localparam int unsigned DW   = 16;

  logic                clk_i = 1'b0;
  logic                arst_ni;
  logic [N_CH-1:0]     req_wre_i;
  logic [N_CH*DW-1:0]  req_data_i;
  logic [N_CH-1:0]     req_rdy_o;
  logic [DW-1:0]       dac_data_o;
  logic [1:0]          dac_ch_o;
  logic                dac_wre_o;
  logic                dac_done_i;
  logic                busy_o;
  logic                timeout_o;
  logic                clr_i;

  int n_checks = 0;
  int n_fail   = 0;

  dac_share_arb #(
    .N_CH    (4),
    .DW      (16),
    .TIMEOUT (8)
  ) dut (
    .clk_i      (clk_i),
    .arst_ni    (arst_ni),
    .req_wre_i  (req_wre_i),
    .req_data_i (req_data_i),
    .req_rdy_o  (req_rdy_o),
    .dac_data_o (dac_data_o),
    .dac_ch_o   (dac_ch_o),
    .dac_wre_o  (dac_wre_o),
    .dac_done_i (dac_done_i),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o),
    .clr_i      (clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_ch(input int ch, input logic [15:0] d);
    req_wre_i[ch]           = 1'b1;
    req_data_i[ch*16 +: 16] = d;
    tick();
    req_wre_i = '0;
  endtask

  task automatic wait_wre(input string tag);
    int n;
    n = 0;
    while (!dac_wre_o && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_wre"}, 32'(dac_wre_o), 1);
  endtask

  // Wait for the write, check it, return done three cycles later.
  task automatic service(input int ch, input logic [15:0] d, input string tag);
    wait_wre(tag);
    check_eq({tag, "_ch"},   32'(dac_ch_o),   ch);
    check_eq({tag, "_data"}, 32'(dac_data_o), 32'(d));
    check_eq({tag, "_busy"}, 32'(busy_o),     1);
    tick();
    tick();
    dac_done_i = 1'b1;
    tick();
    dac_done_i = 1'b0;
    check_eq({tag, "_rdy"},   32'(req_rdy_o[ch]), 1);
    check_eq({tag, "_idle"},  32'(busy_o),        0);
  endtask

  task automatic count_wre(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (dac_wre_o) cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int c;
    arst_ni    = 1'b0;
    req_wre_i  = '0;
    req_data_i = '0;
    dac_done_i = 1'b0;
    clr_i      = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_rdy",  32'(req_rdy_o),  0);
    check_eq("rst_data", 32'(dac_data_o), 0);
    check_eq("rst_ch",   32'(dac_ch_o),   0);
    check_eq("rst_wre",  32'(dac_wre_o),  0);
    check_eq("rst_busy", 32'(busy_o),     0);
    check_eq("rst_to",   32'(timeout_o),  0);
    arst_ni = 1'b1;
    tick();

    // Single request: strobe two edges after the request
    write_ch(2, 16'h1234);
    check_eq("single_nowre", 32'(dac_wre_o), 0);
    tick();
    check_eq("single_wre",  32'(dac_wre_o),  1);
    check_eq("single_data", 32'(dac_data_o), 32'h1234);
    check_eq("single_ch",   32'(dac_ch_o),   2);
    check_eq("single_busy", 32'(busy_o),     1);
    tick();
    check_eq("single_wre_low", 32'(dac_wre_o), 0);
    check_eq("single_rdy0",    32'(req_rdy_o), 0);
    dac_done_i = 1'b1;
    tick();
    dac_done_i = 1'b0;
    check_eq("single_rdy", 32'(req_rdy_o), 32'h4);
    check_eq("single_idle", 32'(busy_o),   0);
    count_wre(3, c);
    check_eq("single_noreissue", c, 0);

    // Round robin from reset state (last grant = 3)
    arst_ni = 1'b0;
    #2;
    arst_ni = 1'b1;
    tick();
    req_wre_i  = 4'hF;
    req_data_i = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    tick();
    req_wre_i = '0;
    service(0, 16'h1000, "rr0");
    service(1, 16'h1001, "rr1");
    service(2, 16'h1002, "rr2");
    service(3, 16'h1003, "rr3");
    check_eq("rr_allrdy", 32'(req_rdy_o), 32'hF);
    req_wre_i  = 4'b1001;
    req_data_i = {16'h2003, 16'h0, 16'h0, 16'h2000};
    tick();
    req_wre_i = '0;
    check_eq("rr_rdy_drop", 32'(req_rdy_o), 32'h6);
    service(0, 16'h2000, "rr_b0");
    service(3, 16'h2003, "rr_b3");

    // Overwrite while another channel is in flight
    write_ch(0, 16'hAAAA);
    wait_wre("ow_ch0");
    check_eq("ow_ch0_ch", 32'(dac_ch_o), 0);
    write_ch(1, 16'h0010);
    write_ch(1, 16'h0020);
    dac_done_i = 1'b1;
    tick();
    dac_done_i = 1'b0;
    service(1, 16'h0020, "ow_ch1");
    count_wre(6, c);
    check_eq("ow_single_write", c, 0);

    // Write arriving in the same cycle as done for the same channel
    write_ch(1, 16'h0011);
    wait_wre("wf_first");
    check_eq("wf_first_data", 32'(dac_data_o), 32'h0011);
    tick();
    dac_done_i             = 1'b1;
    req_wre_i[1]           = 1'b1;
    req_data_i[16 +: 16]   = 16'h0055;
    tick();
    dac_done_i = 1'b0;
    req_wre_i  = '0;
    check_eq("wf_rdy_held", 32'(req_rdy_o[1]), 0);
    service(1, 16'h0055, "wf_second");

    // Timeout: nine WAIT cycles without done, then retry
    write_ch(2, 16'h0BEE);
    wait_wre("to_first");
    repeat (8) tick();
    check_eq("to_not_yet", 32'(timeout_o), 0);
    check_eq("to_busy8",   32'(busy_o),    1);
    tick();
    check_eq("to_set",     32'(timeout_o),    1);
    check_eq("to_idle",    32'(busy_o),       0);
    check_eq("to_rdy",     32'(req_rdy_o[2]), 0);
    tick();
    check_eq("to_retry_wre",  32'(dac_wre_o),  1);
    check_eq("to_retry_ch",   32'(dac_ch_o),   2);
    check_eq("to_retry_data", 32'(dac_data_o), 32'h0BEE);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check_eq("to_clr", 32'(timeout_o), 0);
    dac_done_i = 1'b1;
    tick();
    dac_done_i = 1'b0;
    check_eq("to_done_rdy", 32'(req_rdy_o[2]), 1);

    // Reset in the middle of WAIT
    write_ch(3, 16'h0333);
    wait_wre("rw_first");
    tick();
    check_eq("rw_busy", 32'(busy_o), 1);
    arst_ni = 1'b0;
    #2;
    check_eq("rw_busy0", 32'(busy_o),     0);
    check_eq("rw_rdy0",  32'(req_rdy_o),  0);
    check_eq("rw_data0", 32'(dac_data_o), 0);
    check_eq("rw_ch0",   32'(dac_ch_o),   0);
    check_eq("rw_wre0",  32'(dac_wre_o),  0);
    arst_ni = 1'b1;
    tick();
    dac_done_i = 1'b1;
    tick();
    dac_done_i = 1'b0;
    check_eq("rw_late_done_rdy", 32'(req_rdy_o), 0);
    check_eq("rw_late_done_busy", 32'(busy_o),   0);
    count_wre(4, c);
    check_eq("rw_no_write", c, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_share_arb.md
# dac_share_arb

Round-robin scheduler that shares one threshold DAC between N_CH channel measurement controllers. Each controller posts threshold writes as single-cycle strobes. The block latches the latest value per channel, issues one DAC write at a time, and waits for DAC completion. It then returns a per-channel ready that the controller uses as its threshold-settled input. It sits between the per-channel measure controllers and the DAC write engine in the measure unit.

## Interface
- N_CH, 4, number of requesting channels (2..16)
- DW, 16, threshold/DAC data width
- TIMEOUT, 1023, max cycles in WAIT before abort (≥2)

- clk_i  in  1  clock, all logic on rising edge
- arst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- req_wre_i  in  N_CH  per-channel write strobe, one cycle per write
- req_data_i  in  N_CH*DW  per-channel threshold; channel k at [k*DW +: DW]; sampled when req_wre_i[k]=1
- req_rdy_o  out  N_CH  channel k: last written value is applied at the DAC
- dac_data_o  out  DW  value for the DAC write
- dac_ch_o  out  clog2(N_CH)  channel being serviced
- dac_wre_o  out  1  one-cycle DAC write strobe
- dac_done_i  in  1  one-cycle DAC completion pulse
- busy_o  out  1  write in flight (state WAIT)
- timeout_o  out  1  sticky, set on any WAIT abort
- clr_i  in  1  clears timeout_o

## Operation
- Reset values: req_rdy_o=0, dac_data_o=0, dac_ch_o=0, dac_wre_o=0, busy_o=0, timeout_o=0, all pending=0, last_grant=N_CH-1, state IDLE.
- Per channel k, on req_wre_i[k]:
  - data_q[k] <= req_data_i slice
  - pending[k] <= 1
  - req_rdy_o[k] <= 0
- A second write before service overwrites data_q[k]; only the latest value is issued.
- States:
  - IDLE: if any pending, grant g = first pending index searching last_grant+1, +2, … modulo N_CH. Then:
    - dac_data_o <= data_q[g], dac_ch_o <= g, dac_wre_o <= 1
    - pending[g] <= 0, last_grant <= g
    - reset wait counter; go to WAIT.
  - WAIT: busy_o=1; dac_wre_o back to 0.
    - On dac_done_i: req_rdy_o[g] <= 1 unless pending[g] is set (new write arrived meanwhile); go to IDLE.
    - If the wait counter reaches TIMEOUT without done: timeout_o <= 1, pending[g] <= 1 (retry), req_rdy_o[g] stays 0; go to IDLE.
- dac_done_i outside WAIT is ignored.
- A req_wre_i[g] in the same cycle as done for g wins: pending[g]=1 and req_rdy_o[g]=0.
- A req_wre_i[g] in the same cycle as g is granted: data_q[g] takes the new value and pending[g] stays 1 (set dominates clear). The old value is still issued.
- timeout_o is cleared by clr_i only; a timeout in the same cycle as clr_i leaves timeout_o set.
- Fairness: every pending channel is serviced within N_CH grants.

## Timing
- req_wre_i sampled at edge E0 → pending visible after E0 → grant at E1 → dac_wre_o high for the cycle after E1. Minimum latency is 2 cycles from request to write strobe.
- dac_done_i sampled at edge D → req_rdy_o high after D → next grant at D+1. The minimum gap between consecutive dac_wre_o pulses is 2 cycles plus DAC latency.
- WAIT counter starts at 0 in the first WAIT cycle. Abort at the edge where the count equals TIMEOUT, i.e. TIMEOUT+1 WAIT cycles without done.
- Reset asserted mid-operation immediately forces all reset values.
  - An in-flight DAC write is forgotten; its late dac_done_i is ignored.
  - Controllers must re-request after reset.

## Test plan
- Single request: N_CH=4, req_wre_i[2] with 0x1234 at cycle 0 → dac_wre_o high at cycle 2 with dac_data_o=0x1234, dac_ch_o=2, busy_o=1. After dac_done_i at cycle 5 → req_rdy_o[2]=1 at cycle 6, busy_o=0.
- Round robin: all 4 channels request in the same cycle, done returned 3 cycles after each write → grant order 0,1,2,3. Then re-request 0 and 3 with last_grant=3 → order 0,3.
- Overwrite: ch1 writes 0x0010 then 0x0020 while ch0 is in flight → only one ch1 DAC write, with 0x0020.
- Write during flight: ch1 in WAIT, ch1 writes 0x0055 in the same cycle as dac_done_i → req_rdy_o[1] stays 0 and a second write of 0x0055 is issued. req_rdy_o[1]=1 only after its done.
- Timeout: TIMEOUT=8, never pulse done → after 9 WAIT cycles timeout_o=1 and the same channel is re-issued. A clr_i pulse → timeout_o=0.
- Reset mid-WAIT: drop arst_ni during WAIT → all outputs 0 asynchronously. A dac_done_i after release → no req_rdy_o change.
